// File: rtl/register_writeback_queue_if.sv
// -----------------------------------------------------------------------------
// register_writeback_queue_if
//   Bundle of every non-clock/reset signal of register_writeback_queue.
//   master : producer/decode/register-file side (drives the i_* signals)
//   slave  : the writeback queue itself (drives the o_* signals)
//   Groups:
//     ALU result handshake   i_Alu_Valid/o_Alu_Ready/i_Alu_Addr/i_Alu_Data
//     Load result handshake  i_Load_Valid/o_Load_Ready/i_Load_Addr/i_Load_Data
//     Register file port     i_Write_Hold/o_Write_Enable/o_Write_Addr/o_Write_Data
//     Decode bypass lookups  i_Bypass_Addr_1/2, o_Bypass_Hit_1/2, o_Bypass_Data_1/2
//     Occupancy              o_Count
// -----------------------------------------------------------------------------
interface register_writeback_queue_if #(
   parameter int XLEN           = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int DEPTH          = 4
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic                      i_Alu_Valid;
   logic                      o_Alu_Ready;
   logic [REG_ADDR_WIDTH-1:0] i_Alu_Addr;
   logic [XLEN-1:0]           i_Alu_Data;

   logic                      i_Load_Valid;
   logic                      o_Load_Ready;
   logic [REG_ADDR_WIDTH-1:0] i_Load_Addr;
   logic [XLEN-1:0]           i_Load_Data;

   logic                      i_Write_Hold;
   logic                      o_Write_Enable;
   logic [REG_ADDR_WIDTH-1:0] o_Write_Addr;
   logic [XLEN-1:0]           o_Write_Data;

   logic [REG_ADDR_WIDTH-1:0] i_Bypass_Addr_1;
   logic [REG_ADDR_WIDTH-1:0] i_Bypass_Addr_2;
   logic                      o_Bypass_Hit_1;
   logic                      o_Bypass_Hit_2;
   logic [XLEN-1:0]           o_Bypass_Data_1;
   logic [XLEN-1:0]           o_Bypass_Data_2;

   logic [CNT_W-1:0]          o_Count;

   modport master (
      output i_Alu_Valid, i_Alu_Addr, i_Alu_Data,
      output i_Load_Valid, i_Load_Addr, i_Load_Data,
      output i_Write_Hold,
      output i_Bypass_Addr_1, i_Bypass_Addr_2,
      input  o_Alu_Ready, o_Load_Ready,
      input  o_Write_Enable, o_Write_Addr, o_Write_Data,
      input  o_Bypass_Hit_1, o_Bypass_Hit_2, o_Bypass_Data_1, o_Bypass_Data_2,
      input  o_Count
   );

   modport slave (
      input  i_Alu_Valid, i_Alu_Addr, i_Alu_Data,
      input  i_Load_Valid, i_Load_Addr, i_Load_Data,
      input  i_Write_Hold,
      input  i_Bypass_Addr_1, i_Bypass_Addr_2,
      output o_Alu_Ready, o_Load_Ready,
      output o_Write_Enable, o_Write_Addr, o_Write_Data,
      output o_Bypass_Hit_1, o_Bypass_Hit_2, o_Bypass_Data_1, o_Bypass_Data_2,
      output o_Count
   );
endinterface

// File: rtl/register_writeback_queue.sv
// -----------------------------------------------------------------------------
// register_writeback_queue
//   Write-side front end of the register file. ALU and load results arrive over
//   valid/ready handshakes, are buffered in a DEPTH-entry FIFO and drained one
//   per cycle into the single register-file write port. Two combinational
//   bypass lookups report the youngest queued value for a decode read address.
// Ports
//   i_Clock    : clock, all state on posedge
//   i_Reset_n  : asynchronous active-low reset
//   bus        : register_writeback_queue_if.slave (handshakes, write port,
//                bypass lookups, occupancy count)
// -----------------------------------------------------------------------------
module register_writeback_queue #(
   parameter int XLEN           = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int DEPTH          = 4
) (
   input logic                        i_Clock,
   input logic                        i_Reset_n,
   register_writeback_queue_if.slave  bus
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [REG_ADDR_WIDTH-1:0] addr_mem_r [DEPTH];
   logic [XLEN-1:0]           data_mem_r [DEPTH];
   logic [PTR_W-1:0]          rd_ptr_r;
   logic [PTR_W-1:0]          wr_ptr_r;
   logic [CNT_W-1:0]          count_r;
   // 0 = load wins the next contested slot, 1 = ALU wins
   logic                      rr_alu_first_r;

   logic [CNT_W-1:0]          free_s;
   logic                      alu_ready_s;
   logic                      load_ready_s;
   logic                      alu_push_s;
   logic                      load_push_s;
   logic                      contest_s;
   logic                      pop_s;
   logic [PTR_W-1:0]          alu_slot_s;
   logic [PTR_W-1:0]          age_slot_s [DEPTH];
   logic [DEPTH-1:0]          match_1_s;
   logic [DEPTH-1:0]          match_2_s;
   logic                      bypass_hit_1_s;
   logic                      bypass_hit_2_s;
   logic [XLEN-1:0]           bypass_data_1_s;
   logic [XLEN-1:0]           bypass_data_2_s;

   // Free slots come from the registered count only: a same-cycle pop never
   // frees room for a same-cycle push, so pushes can never overrun.
   assign free_s = CNT_W'(DEPTH) - count_r;

   // Ready generation; each Ready looks only at the other source's Valid.
   always_comb begin
      alu_ready_s  = 1'b0;
      load_ready_s = 1'b0;
      if (free_s >= CNT_W'(2)) begin
         alu_ready_s  = 1'b1;
         load_ready_s = 1'b1;
      end else if (free_s == CNT_W'(1)) begin
         load_ready_s = !bus.i_Alu_Valid  || !rr_alu_first_r;
         alu_ready_s  = !bus.i_Load_Valid ||  rr_alu_first_r;
      end else begin
         alu_ready_s  = 1'b0;
         load_ready_s = 1'b0;
      end
   end

   // Writes to x0 complete the handshake but never occupy a slot.
   assign load_push_s = bus.i_Load_Valid && load_ready_s &&
                        (bus.i_Load_Addr != {REG_ADDR_WIDTH{1'b0}});
   assign alu_push_s  = bus.i_Alu_Valid && alu_ready_s &&
                        (bus.i_Alu_Addr != {REG_ADDR_WIDTH{1'b0}});
   assign contest_s   = (free_s == CNT_W'(1)) && bus.i_Load_Valid && bus.i_Alu_Valid;
   assign pop_s       = (count_r != {CNT_W{1'b0}}) && !bus.i_Write_Hold;
   // Load is the older of a same-cycle pair, so the ALU entry lands behind it.
   assign alu_slot_s  = wr_ptr_r + PTR_W'(load_push_s);

   assign bus.o_Alu_Ready    = alu_ready_s;
   assign bus.o_Load_Ready   = load_ready_s;
   assign bus.o_Write_Enable = pop_s;
   assign bus.o_Write_Addr   = addr_mem_r[rd_ptr_r];
   assign bus.o_Write_Data   = data_mem_r[rd_ptr_r];
   assign bus.o_Count        = count_r;
   assign bus.o_Bypass_Hit_1  = bypass_hit_1_s;
   assign bus.o_Bypass_Hit_2  = bypass_hit_2_s;
   assign bus.o_Bypass_Data_1 = bypass_data_1_s;
   assign bus.o_Bypass_Data_2 = bypass_data_2_s;

   // Physical slot of the i-th oldest entry (0 = head).
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         age_slot_s[i] = rd_ptr_r + PTR_W'(i);
      end
   end

   // Per-entry address matches for both lookups; x0 never matches.
   always_comb begin
      match_1_s = {DEPTH{1'b0}};
      match_2_s = {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         match_1_s[i] = (CNT_W'(i) < count_r) &&
                        (bus.i_Bypass_Addr_1 != {REG_ADDR_WIDTH{1'b0}}) &&
                        (addr_mem_r[age_slot_s[i]] == bus.i_Bypass_Addr_1);
         match_2_s[i] = (CNT_W'(i) < count_r) &&
                        (bus.i_Bypass_Addr_2 != {REG_ADDR_WIDTH{1'b0}}) &&
                        (addr_mem_r[age_slot_s[i]] == bus.i_Bypass_Addr_2);
      end
   end

   // Youngest-wins select: walk oldest to youngest so later matches override.
   always_comb begin
      bypass_hit_1_s  = 1'b0;
      bypass_hit_2_s  = 1'b0;
      bypass_data_1_s = {XLEN{1'b0}};
      bypass_data_2_s = {XLEN{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         bypass_hit_1_s  = bypass_hit_1_s | match_1_s[i];
         bypass_hit_2_s  = bypass_hit_2_s | match_2_s[i];
         bypass_data_1_s = match_1_s[i] ? data_mem_r[age_slot_s[i]] : bypass_data_1_s;
         bypass_data_2_s = match_2_s[i] ? data_mem_r[age_slot_s[i]] : bypass_data_2_s;
      end
   end

   // Queue storage, pointers, occupancy and round-robin state.
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         rd_ptr_r       <= {PTR_W{1'b0}};
         wr_ptr_r       <= {PTR_W{1'b0}};
         count_r        <= {CNT_W{1'b0}};
         rr_alu_first_r <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_mem_r[i] <= {REG_ADDR_WIDTH{1'b0}};
            data_mem_r[i] <= {XLEN{1'b0}};
         end
      end else begin
         if (load_push_s) begin
            addr_mem_r[wr_ptr_r] <= bus.i_Load_Addr;
            data_mem_r[wr_ptr_r] <= bus.i_Load_Data;
         end
         if (alu_push_s) begin
            addr_mem_r[alu_slot_s] <= bus.i_Alu_Addr;
            data_mem_r[alu_slot_s] <= bus.i_Alu_Data;
         end
         wr_ptr_r <= wr_ptr_r + PTR_W'(load_push_s) + PTR_W'(alu_push_s);
         rd_ptr_r <= rd_ptr_r + PTR_W'(pop_s);
         count_r  <= count_r + CNT_W'(load_push_s) + CNT_W'(alu_push_s) - CNT_W'(pop_s);
         // After a contested grant the bit points at the loser; a discarded
         // x0 winner leaves the priority where it was.
         if (contest_s) begin
            if (rr_alu_first_r) begin
               if (alu_push_s) begin
                  rr_alu_first_r <= 1'b0;
               end
            end else begin
               if (load_push_s) begin
                  rr_alu_first_r <= 1'b1;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_register_writeback_queue.sv
// -----------------------------------------------------------------------------
// tb_register_writeback_queue
//   Directed scenarios followed by randomized traffic. A queue-based reference
//   model predicts Ready, Count, Write_Enable and bypass results each cycle; every
//   accepted non-x0 result is pushed into a scoreboard that a separate monitor
//   pops whenever the DUT strobes o_Write_Enable.
// -----------------------------------------------------------------------------
module tb_register_writeback_queue;
   localparam int XLEN  = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;
   } entry_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   entry_t mdl_q[$];
   entry_t exp_q[$];
   logic   pref_alu;

   register_writeback_queue_if #(.XLEN(XLEN), .REG_ADDR_WIDTH(AW), .DEPTH(DEPTH)) bus ();

   register_writeback_queue #(.XLEN(XLEN), .REG_ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
      .i_Clock   (clk),
      .i_Reset_n (rst_n),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Youngest queued value for an address, from the model's contents.
   task automatic lookup(input logic [AW-1:0] a, output logic hit, output logic [XLEN-1:0] d);
      hit = 1'b0;
      d   = '0;
      if (a != 5'd0) begin
         foreach (mdl_q[i]) begin
            if (mdl_q[i].addr == a) begin
               hit = 1'b1;
               d   = mdl_q[i].data;
            end
         end
      end
   endtask

   // One clock cycle: drive, check outputs against the model, advance the model.
   task automatic step(input logic lv, input logic [AW-1:0] la, input logic [XLEN-1:0] ld,
                       input logic av, input logic [AW-1:0] aa, input logic [XLEN-1:0] ad,
                       input logic hold, input logic [AW-1:0] b1, input logic [AW-1:0] b2);
      int free;
      logic lr, ar, we, h1, h2;
      logic [XLEN-1:0] d1, d2;
      entry_t e;
      @(posedge clk);
      #2;
      bus.i_Load_Valid = lv;  bus.i_Load_Addr = la;  bus.i_Load_Data = ld;
      bus.i_Alu_Valid  = av;  bus.i_Alu_Addr  = aa;  bus.i_Alu_Data  = ad;
      bus.i_Write_Hold = hold;
      bus.i_Bypass_Addr_1 = b1;
      bus.i_Bypass_Addr_2 = b2;
      #4;
      free = DEPTH - mdl_q.size();
      lr = 1'b0;
      ar = 1'b0;
      if (free >= 2) begin
         lr = 1'b1;
         ar = 1'b1;
      end else if (free == 1) begin
         lr = !av || !pref_alu;
         ar = !lv ||  pref_alu;
      end
      we = (mdl_q.size() != 0) && !hold;
      lookup(b1, h1, d1);
      lookup(b2, h2, d2);
      chk("load_ready",   bus.o_Load_Ready,    lr);
      chk("alu_ready",    bus.o_Alu_Ready,     ar);
      chk("count",        bus.o_Count,         mdl_q.size());
      chk("write_enable", bus.o_Write_Enable,  we);
      chk("bypass_hit_1", bus.o_Bypass_Hit_1,  h1);
      chk("bypass_data_1",bus.o_Bypass_Data_1, d1);
      chk("bypass_hit_2", bus.o_Bypass_Hit_2,  h2);
      chk("bypass_data_2",bus.o_Bypass_Data_2, d2);
      // State after the coming edge
      if (free == 1 && lv && av) begin
         if (pref_alu) begin
            if (aa != 5'd0) pref_alu = 1'b0;
         end else begin
            if (la != 5'd0) pref_alu = 1'b1;
         end
      end
      if (we) mdl_q.delete(0);
      if (lv && lr && la != 5'd0) begin
         e.addr = la; e.data = ld;
         mdl_q.push_back(e);
         exp_q.push_back(e);
      end
      if (av && ar && aa != 5'd0) begin
         e.addr = aa; e.data = ad;
         mdl_q.push_back(e);
         exp_q.push_back(e);
      end
   endtask

   task automatic idle(input logic hold);
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, hold, 5'd0, 5'd0);
   endtask

   // Monitor: every register-file write must match the oldest expected result.
   initial begin
      entry_t e;
      forever begin
         @(posedge clk);
         #7;
         if (rst_n && bus.o_Write_Enable) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: addr %0h data %0h with empty scoreboard",
                        bus.o_Write_Addr, bus.o_Write_Data);
            end else begin
               e = exp_q.pop_front();
               chk("write_addr", bus.o_Write_Addr, e.addr);
               chk("write_data", bus.o_Write_Data, e.data);
            end
         end
      end
   end

   initial begin
      checks   = 0;
      errors   = 0;
      pref_alu = 1'b0;
      rst_n    = 1'b0;
      bus.i_Load_Valid = 1'b0; bus.i_Load_Addr = '0; bus.i_Load_Data = '0;
      bus.i_Alu_Valid  = 1'b0; bus.i_Alu_Addr  = '0; bus.i_Alu_Data  = '0;
      bus.i_Write_Hold = 1'b0;
      bus.i_Bypass_Addr_1 = 5'd5;
      bus.i_Bypass_Addr_2 = 5'd0;
      #3;
      chk("reset_count", bus.o_Count,        3'd0);
      chk("reset_we",    bus.o_Write_Enable, 1'b0);
      chk("reset_hit_1", bus.o_Bypass_Hit_1, 1'b0);
      #10;
      rst_n = 1'b1;

      // Single ALU write drains the next cycle
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd5, 5'd0);
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,         1'b0, 5'd5, 5'd0);
      idle(1'b0);

      // Same-cycle load+ALU to one register: ALU is younger, load drains first
      step(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 1'b1, 5'd3, 5'd0);
      step(1'b0, 5'd0, 32'd0,  1'b0, 5'd0, 32'd0,  1'b1, 5'd3, 5'd3);
      for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd3, 5'd0);

      // Fill under hold, confirm both Ready drop, then four back-to-back drains
      for (int i = 0; i < 5; i++)
         step(1'b0, 5'd0, 32'd0, 1'b1, 5'(i + 1), 32'h100 + 32'(i), 1'b1, 5'(i + 1), 5'd2);
      step(1'b1, 5'd7, 32'h77, 1'b1, 5'd8, 32'h88, 1'b1, 5'd1, 5'd4);
      for (int i = 0; i < 5; i++) idle(1'b0);

      // Contested last slot: grants alternate as slots free
      for (int i = 0; i < 3; i++)
         step(1'b0, 5'd0, 32'd0, 1'b1, 5'(10 + i), 32'h200 + 32'(i), 1'b1, 5'd0, 5'd0);
      for (int i = 0; i < 8; i++)
         step(1'b1, 5'(20 + i), 32'h300 + 32'(i), 1'b1, 5'(21 + i), 32'h400 + 32'(i),
              (i % 2 == 0), 5'(20 + i), 5'(21 + i));
      for (int i = 0; i < 5; i++) idle(1'b0);

      // x0 write: accepted, discarded, never visible
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 5'd0);
      step(1'b1, 5'd0, 32'h66, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
      idle(1'b0);

      // Reset while three entries are queued and draining
      for (int i = 0; i < 3; i++)
         step(1'b0, 5'd0, 32'd0, 1'b1, 5'(4 + i), 32'h500 + 32'(i), 1'b1, 5'd0, 5'd0);
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd4, 5'd5);
      rst_n = 1'b0;
      #2;
      chk("midreset_we",    bus.o_Write_Enable, 1'b0);
      chk("midreset_count", bus.o_Count,        3'd0);
      chk("midreset_hit_1", bus.o_Bypass_Hit_1, 1'b0);
      chk("midreset_hit_2", bus.o_Bypass_Hit_2, 1'b0);
      mdl_q.delete();
      exp_q.delete();
      pref_alu = 1'b0;
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      idle(1'b0);
      idle(1'b0);

      // Randomized traffic
      for (int i = 0; i < 400; i++)
         step(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
              ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
              ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      for (int i = 0; i < DEPTH + 3; i++) idle(1'b0);
      #2;
      chk("scoreboard_empty", exp_q.size(), 0);
      chk("final_count",      bus.o_Count,  3'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
